// File: rtl/packet_accum_mc.sv
// Multi-channel packet accumulator: per-channel sum/min/max/saturating-sum over
// interleaved packet beats, with finished results queued in a small output FIFO.
module packet_accum_mc #(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int RES_W     = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [RES_W-1:0]  out_result,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic [NUM_CH-1:0] busy,
  output logic              err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {OP_SUM = 2'b00, OP_MIN = 2'b01, OP_MAX = 2'b10, OP_SAT = 2'b11} op_e;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [RES_W-1:0] result;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } res_t;

  // Per-channel packet state
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] ovf;
  logic [RES_W-1:0]  acc  [NUM_CH];
  logic [CNT_W-1:0]  cnt  [NUM_CH];
  op_e               mode [NUM_CH];

  logic             sel_active, sel_ovf, nxt_ovf;
  logic [RES_W-1:0] sel_acc, nxt_acc;
  logic [CNT_W-1:0] sel_cnt, nxt_cnt;
  op_e              sel_mode, nxt_mode;
  logic [RES_W:0]   sum_full;
  logic             ch_ok, accept, take, push, pop, bad;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fill;
  logic             fresh;
  res_t             mem [FIFO_DEPTH];
  res_t             head;

  assign ch_ok    = (int'(in_ch) < NUM_CH);
  assign in_ready = (fill != (PTR_W+1)'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    sel_active = 1'b0;
    sel_ovf    = 1'b0;
    sel_acc    = '0;
    sel_cnt    = '0;
    sel_mode   = OP_SUM;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_ok && in_ch == CH_W'(c)) begin
        sel_active = active[c];
        sel_ovf    = ovf[c];
        sel_acc    = acc[c];
        sel_cnt    = cnt[c];
        sel_mode   = mode[c];
      end
    end

    sum_full = {1'b0, sel_acc} + {{(CNT_W+1){1'b0}}, in_data};
    nxt_acc  = sel_acc;
    nxt_cnt  = sel_cnt;
    nxt_ovf  = sel_ovf;
    nxt_mode = sel_mode;
    if (in_first) begin
      nxt_acc  = {{CNT_W{1'b0}}, in_data};
      nxt_cnt  = CNT_W'(1);
      nxt_ovf  = 1'b0;
      nxt_mode = op_e'(in_mode);
    end else begin
      unique case (sel_mode)
        OP_SUM: nxt_acc = sum_full[RES_W-1:0];
        OP_SAT: begin
          if (sum_full[RES_W]) begin
            nxt_acc = '1;
            nxt_ovf = 1'b1;
          end else begin
            nxt_acc = sum_full[RES_W-1:0];
          end
        end
        OP_MIN: if (in_data < sel_acc[DATA_W-1:0]) nxt_acc = {{CNT_W{1'b0}}, in_data};
        OP_MAX: if (in_data > sel_acc[DATA_W-1:0]) nxt_acc = {{CNT_W{1'b0}}, in_data};
        default: nxt_acc = sel_acc;
      endcase
      // Count sticks at all-ones; the extra beat is still combined above
      if (&sel_cnt) nxt_ovf = 1'b1;
      else          nxt_cnt = sel_cnt + 1'b1;
    end
  end

  assign take = accept && ch_ok && (in_first || sel_active);
  assign push = take && in_last;
  assign bad  = accept && (!ch_ok || (in_first ? sel_active : !sel_active));

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
      ovf    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]  <= '0;
        cnt[c]  <= '0;
        mode[c] <= OP_SUM;
      end
    end else if (take) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_ch == CH_W'(c)) begin
          acc[c]    <= nxt_acc;
          cnt[c]    <= nxt_cnt;
          mode[c]   <= nxt_mode;
          ovf[c]    <= nxt_ovf;
          active[c] <= !in_last;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= bad;
  end

  assign busy = active;

  // A freshly written entry becomes visible one cycle after its write
  assign out_valid = (fill > {{PTR_W{1'b0}}, fresh});
  assign pop       = out_valid && out_ready;

  // NOTE: FIFO storage is not reset; the head is masked by out_valid instead,
  // so stale contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ch: in_ch, result: nxt_acc, count: nxt_cnt, ovf: nxt_ovf};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      fresh  <= 1'b0;
    end else begin
      fresh <= push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  assign head       = out_valid ? mem[rd_ptr] : '0;
  assign out_ch     = head.ch;
  assign out_result = head.result;
  assign out_count  = head.count;
  assign out_ovf    = head.ovf;

endmodule

// File: tb/tb_packet_accum_mc.sv
// Self-checking bench for packet_accum_mc: directed scenarios plus random
// interleaved traffic, compared against a list-based packet model.
module tb_packet_accum_mc;

  localparam int DATA_W     = 8;
  localparam int NUM_CH     = 3;
  localparam int CNT_W      = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_W       = 2;
  localparam int RES_W      = DATA_W + CNT_W;
  localparam longint MAXR   = (longint'(1) << RES_W) - 1;
  localparam int MAXC       = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [RES_W-1:0] result;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_first, in_last;
  logic [CH_W-1:0]   in_ch;
  logic [1:0]        in_mode;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_ready, out_ovf, err;
  logic [CH_W-1:0]   out_ch;
  logic [RES_W-1:0]  out_result;
  logic [CNT_W-1:0]  out_count;
  logic [NUM_CH-1:0] busy;

  packet_accum_mc #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_first(in_first),
    .in_last(in_last), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_result(out_result),
    .out_count(out_count), .out_ovf(out_ovf), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each open packet is the plain list of its beats
  bit           m_active [NUM_CH];
  bit [1:0]     m_mode   [NUM_CH];
  int unsigned  m_beats  [NUM_CH][$];
  res_t         exp_q[$];
  bit           m_fresh;
  bit           last_acc;

  function automatic res_t finish_pkt(int c);
    res_t r;
    longint total_sum = 0;
    longint mn, mx;
    int n = m_beats[c].size();
    mn = longint'(m_beats[c][0]);
    mx = mn;
    for (int i = 0; i < n; i++) begin
      longint v = longint'(m_beats[c][i]);
      total_sum += v;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    r.ch  = CH_W'(c);
    r.ovf = 1'b0;
    case (m_mode[c])
      2'd0: r.result = RES_W'(total_sum % (MAXR + 1));
      2'd1: r.result = RES_W'(mn);
      2'd2: r.result = RES_W'(mx);
      default: begin
        if (total_sum > MAXR) begin
          r.result = RES_W'(MAXR);
          r.ovf    = 1'b1;
        end else begin
          r.result = RES_W'(total_sum);
        end
      end
    endcase
    if (n > MAXC) begin
      r.count = CNT_W'(MAXC);
      r.ovf   = 1'b1;
    end else begin
      r.count = CNT_W'(n);
    end
    return r;
  endfunction

  task automatic reset_model();
    for (int c = 0; c < NUM_CH; c++) begin
      m_active[c] = 1'b0;
      m_beats[c].delete();
    end
    exp_q.delete();
    m_fresh = 1'b0;
  endtask

  // One clock cycle: check outputs, predict this edge, advance, check registered flags
  task automatic step();
    bit exp_ready, exp_valid, acc, pop, push, exp_err, took;
    logic [NUM_CH-1:0] exp_busy;
    res_t pr;
    int c;
    exp_ready = exp_q.size() < FIFO_DEPTH;
    exp_valid = exp_q.size() > (m_fresh ? 1 : 0);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("out_ch", 64'(out_ch), 64'(exp_q[0].ch));
      check("out_result", 64'(out_result), 64'(exp_q[0].result));
      check("out_count", 64'(out_count), 64'(exp_q[0].count));
      check("out_ovf", 64'(out_ovf), 64'(exp_q[0].ovf));
    end
    acc     = in_valid && exp_ready;
    pop     = exp_valid && out_ready;
    push    = 1'b0;
    exp_err = 1'b0;
    pr      = '0;
    if (acc) begin
      if (int'(in_ch) >= NUM_CH) begin
        exp_err = 1'b1;
      end else begin
        c    = int'(in_ch);
        took = in_first || m_active[c];
        if (in_first) begin
          if (m_active[c]) exp_err = 1'b1;
          m_beats[c].delete();
          m_beats[c].push_back(32'(in_data));
          m_mode[c]   = in_mode;
          m_active[c] = 1'b1;
        end else if (!m_active[c]) begin
          exp_err = 1'b1;
        end else begin
          m_beats[c].push_back(32'(in_data));
        end
        if (took && in_last) begin
          pr          = finish_pkt(c);
          push        = 1'b1;
          m_active[c] = 1'b0;
        end
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(pr);
    m_fresh = push;
    for (int k = 0; k < NUM_CH; k++) exp_busy[k] = m_active[k];
    check("err", 64'(err), 64'(exp_err));
    check("busy", 64'(busy), 64'(exp_busy));
  endtask

  task automatic beat(input bit v, input int ch, input bit f, input bit l,
                      input int mode, input int data);
    in_valid = v;
    in_ch    = CH_W'(ch);
    in_first = f;
    in_last  = l;
    in_mode  = 2'(mode);
    in_data  = DATA_W'(data);
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    rst_n = 1'b0;
    in_valid = 1'b0; in_ch = '0; in_first = 1'b0; in_last = 1'b0;
    in_mode = '0; in_data = '0; out_ready = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_fields", 64'({out_ch, out_result, out_count, out_ovf}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    // Simple sum packet on ch0
    beat(1, 0, 1, 0, 0, 5);
    beat(1, 0, 0, 0, 0, 7);
    beat(1, 0, 0, 1, 0, 9);
    check("t1_not_yet_valid", 64'(out_valid), 64'd0);
    idle();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_result", 64'(out_result), 64'd21);
    check("t1_count", 64'(out_count), 64'd3);
    check("t1_ovf", 64'(out_ovf), 64'd0);
    drain();

    // Interleaved max on ch1 and min on ch2
    beat(1, 1, 1, 0, 2, 3);
    beat(1, 2, 1, 0, 1, 40);
    beat(1, 1, 0, 0, 2, 200);
    beat(1, 2, 0, 1, 1, 8);
    beat(1, 1, 0, 1, 2, 17);
    idle();
    check("il_first_ch", 64'(out_ch), 64'd2);
    check("il_first_res", 64'(out_result), 64'd8);
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    check("il_second_ch", 64'(out_ch), 64'd1);
    check("il_second_res", 64'(out_result), 64'd200);
    drain();

    // Saturating sum with count saturation, without and with clipping
    beat(1, 0, 1, 0, 3, 8'h80);
    for (int i = 0; i < 3; i++) beat(1, 0, 0, 0, 3, 8'h80);
    beat(1, 0, 0, 1, 3, 8'h80);
    idle();
    check("sat_res", 64'(out_result), 64'h280);
    check("sat_count", 64'(out_count), 64'd3);
    check("sat_ovf", 64'(out_ovf), 64'd1);
    drain();
    beat(1, 0, 1, 0, 3, 8'hFF);
    for (int i = 0; i < 3; i++) beat(1, 0, 0, 0, 3, 8'hFF);
    beat(1, 0, 0, 1, 3, 8'hFF);
    idle();
    check("clip_res", 64'(out_result), 64'h3FF);
    check("clip_ovf", 64'(out_ovf), 64'd1);
    drain();

    // FIFO full backpressure
    for (int i = 1; i <= 4; i++) beat(1, 0, 1, 1, 0, i);
    in_data = 8'd5;
    step();
    check("full_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      step();
      if (last_acc) done = 1'b1;
    end
    check("full_5th_taken", 64'(done), 64'd1);
    drain();

    // Protocol errors
    beat(1, 2, 0, 0, 0, 9);
    check("proto_mid_idle_err", 64'(err), 64'd1);
    beat(1, 3, 1, 1, 0, 9);
    check("proto_bad_ch_err", 64'(err), 64'd1);
    beat(1, 0, 1, 0, 0, 10);
    beat(1, 0, 1, 0, 0, 20);
    check("proto_refirst_err", 64'(err), 64'd1);
    beat(1, 0, 0, 1, 0, 30);
    idle();
    check("proto_new_sum", 64'(out_result), 64'd50);
    drain();

    // Reset mid-packet with two queued results
    beat(1, 0, 1, 1, 0, 11);
    beat(1, 1, 1, 1, 0, 12);
    beat(1, 0, 1, 0, 0, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset_model();
    rst_n = 1'b1;
    beat(1, 1, 1, 0, 0, 1);
    beat(1, 1, 0, 1, 0, 2);
    idle();
    check("mrst_new_res", 64'(out_result), 64'd3);
    drain();

    // Random interleaved traffic
    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ch     = ($urandom_range(0, 9) == 0) ? 2'd3 : CH_W'($urandom_range(0, NUM_CH - 1));
      in_first  = ($urandom_range(0, 3) == 0);
      in_last   = ($urandom_range(0, 3) == 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_data   = $urandom_range(0, 1) ? DATA_W'($urandom) : DATA_W'($urandom_range(200, 255));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
